// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: default width,
// window word type and the fill-counter width helper.
package seq_det_pkg;

   localparam int SEQ_W = 6;

   typedef logic [SEQ_W-1:0] seq_word_t;

   // Bits needed to hold values 0..v-1; called with W+1 so the count reaches W.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_det_if.sv
// Serial-stream bundle: bit x and live pattern match flow in, window q and
// detect flag z flow out.
interface seq_det_if
   import seq_det_pkg::*;
#(
   parameter int W = SEQ_W
) ();

   logic         x;
   logic [W-1:0] match;
   logic [W-1:0] q;
   logic         z;

   modport master (output x, output match, input q, input z);
   modport slave  (input x, input match, output q, output z);

endinterface

// File: rtl/seq_det_shreg.sv
// W-bit serial window plus a saturating fill counter that reports when
// W real bits have entered since the last reset.
module seq_det_shreg
   import seq_det_pkg::*;
#(
   parameter int W = SEQ_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         x,
   output logic [W-1:0] q,
   output logic         full
);

   localparam int FW = clog2(W + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(W);

   logic [FW-1:0] fill;

   // NOTE: sequential state uses non-blocking assignments so q and fill both
   // update from their pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q    <= '0;
         fill <= '0;
      end else begin
         q <= {q[W-2:0], x};
         if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
   end

   // Gates detection until the reset-zero window has been fully displaced.
   assign full = (fill == FILL_MAX);

endmodule

// File: rtl/seq_det.sv
// Programmable serial pattern detector: z is high whenever the filled window
// equals the live match pattern; overlapping hits are all reported.
module seq_det
   import seq_det_pkg::*;
#(
   parameter int W = SEQ_W
) (
   input logic      clk,
   input logic      rst,
   seq_det_if.slave bus
);

   logic [W-1:0] q;
   logic         full;

   seq_det_shreg #(.W(W)) u_shreg (
      .clk  (clk),
      .rst  (rst),
      .x    (bus.x),
      .q    (q),
      .full (full)
   );

   assign bus.q = q;
   // Combinational against the live match, so a pattern change shows without an edge.
   assign bus.z = full & (q == bus.match);

endmodule

// File: tb/tb_seq_det.sv
// Self-checking bench for seq_det: directed scenarios followed by random
// stream/pattern/reset traffic, all judged against a bit-history model.
module tb_seq_det;
   import seq_det_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bit   hist[$];

   seq_det_if #(.W(SEQ_W)) bus ();

   seq_det #(.W(SEQ_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   // Expected window: the last SEQ_W bits seen since reset, newest in bit 0.
   function automatic seq_word_t model_q();
      seq_word_t v;
      int n;
      v = '0;
      n = hist.size();
      for (int i = 0; i < n; i++) v[i] = hist[n-1-i];
      return v;
   endfunction

   function automatic logic model_z();
      return (hist.size() == SEQ_W) && (model_q() == bus.match);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".q"}, 32'(bus.q), 32'(model_q()));
      check({tag, ".z"}, 32'(bus.z), 32'(model_z()));
   endtask

   // Drive x just after an edge, take the next edge, update the model, sample.
   task automatic step(input logic b);
      bus.x = b;
      @(posedge clk);
      if (!rst) hist.delete();
      else begin
         hist.push_back(b);
         if (hist.size() > SEQ_W) void'(hist.pop_front());
      end
      #1;
   endtask

   task automatic shift_word(input seq_word_t w, input string tag);
      for (int i = SEQ_W - 1; i >= 0; i--) begin
         step(w[i]);
         check_model(tag);
         if (i > 0) check({tag, ".guard"}, 32'(bus.z), 32'(0));
      end
   endtask

   initial begin
      seq_word_t pats[4];
      errors = 0;
      checks = 0;
      rst = 1'b0;
      bus.x = 1'b0;
      bus.match = 6'b110011;

      // Reset with x toggling
      step(1'b1);
      check("rst_z_low", 32'(bus.z), 32'(0));
      step(1'b0);
      check("rst_q", 32'(bus.q), 32'(6'b000000));
      check("rst_z", 32'(bus.z), 32'(0));
      check_model("rst");

      // Basic hit, z held low for the first 5 edges
      rst = 1'b1;
      shift_word(6'b110011, "basic");
      check("basic_q", 32'(bus.q), 32'(6'b110011));
      check("basic_z", 32'(bus.z), 32'(1));
      step(1'b0);
      check("after_q", 32'(bus.q), 32'(6'b100110));
      check("after_z", 32'(bus.z), 32'(0));

      // Overlap continuing with 0,1,1
      step(1'b0);
      check("ovl_q1", 32'(bus.q), 32'(6'b001100));
      step(1'b1);
      check("ovl_q2", 32'(bus.q), 32'(6'b011001));
      check("ovl_z2", 32'(bus.z), 32'(0));
      step(1'b1);
      check("ovl_q3", 32'(bus.q), 32'(6'b110011));
      check("ovl_z3", 32'(bus.z), 32'(1));

      // Live match change without a clock edge
      bus.match = 6'b110010;
      #1;
      check("live_drop", 32'(bus.z), 32'(0));
      bus.match = 6'b110011;
      #1;
      check("live_rise", 32'(bus.z), 32'(1));

      // Mid-stream reset then re-fill
      rst = 1'b0;
      step(1'b1);
      check("mid_rst_q", 32'(bus.q), 32'(0));
      check("mid_rst_z", 32'(bus.z), 32'(0));
      rst = 1'b1;
      shift_word(6'b110011, "refill");
      check("refill_z", 32'(bus.z), 32'(1));

      // Fill guard on an all-zero pattern
      rst = 1'b0;
      step(1'b0);
      rst = 1'b1;
      bus.match = 6'b000000;
      shift_word(6'b000000, "zero");
      check("zero_z6", 32'(bus.z), 32'(1));
      step(1'b0);
      check("zero_z7", 32'(bus.z), 32'(1));

      // All-ones pattern hits on every cycle once filled
      bus.match = 6'b111111;
      for (int i = 0; i < 9; i++) begin
         step(1'b1);
         check_model("ones");
         if (i >= 5) check("ones_z", 32'(bus.z), 32'(1));
      end

      // Random traffic against the history model
      pats[0] = 6'b101101;
      pats[1] = 6'b000111;
      pats[2] = 6'b111111;
      pats[3] = 6'b010101;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 15) == 0) bus.match = pats[$urandom_range(0, 3)];
         step(1'($urandom_range(0, 1)));
         check_model("rand");
         if ($urandom_range(0, 7) == 0) begin
            bus.match = ($urandom_range(0, 1) != 0) ? model_q() : seq_word_t'($urandom);
            #1;
            check_model("rand_live");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
